// File: rtl/jtag_unlock_ctrl.sv
`timescale 1ns/1ps
// Debug-port unlock controller. A 24-bit key, entered as four 6-bit words, opens a timed unlock window.
// Define JTAG_UNLOCK_LOCKOUT_EN to add the failure counter and the sticky LOCKOUT state.
module jtag_unlock_ctrl #(
    parameter logic [23:0] KEY       = 24'h5A3C96,
    parameter int          MAX_FAILS = 3,
    parameter int          TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [5:0] key_data,
    output logic       key_ready,
    input  logic       abort,
    input  logic       relock,
    output logic       unlock_o,
    output logic       update_o,
    output logic       fail_o,
    output logic [1:0] fail_cnt_o,
    output logic       locked_out_o
);

`ifdef JTAG_UNLOCK_LOCKOUT_EN
    localparam bit LOCKOUT_EN = 1'b1;
`else
    localparam bit LOCKOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_LOCKED,
        ST_COLLECT,
        ST_CHECK,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_t;

    state_t      state_reg, state_next;
    logic [23:0] key_buf_reg, key_buf_next;
    logic [1:0]  word_cnt_reg, word_cnt_next;
    logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
    logic [1:0]  fail_cnt_reg, fail_cnt_next;
    logic        unlock_reg, unlock_next;
    logic        update_reg, update_next;
    logic        fail_reg, fail_next;
    logic        word_accept;

    assign key_ready   = (state_reg == ST_LOCKED) || (state_reg == ST_COLLECT);
    assign word_accept = key_valid && key_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_LOCKED;
            key_buf_reg  <= '0;
            word_cnt_reg <= '0;
            tmo_cnt_reg  <= '0;
            fail_cnt_reg <= '0;
            unlock_reg   <= 1'b0;
            update_reg   <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            key_buf_reg  <= key_buf_next;
            word_cnt_reg <= word_cnt_next;
            tmo_cnt_reg  <= tmo_cnt_next;
            fail_cnt_reg <= fail_cnt_next;
            unlock_reg   <= unlock_next;
            update_reg   <= update_next;
            fail_reg     <= fail_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        key_buf_next  = key_buf_reg;
        word_cnt_next = word_cnt_reg;
        tmo_cnt_next  = tmo_cnt_reg;
        fail_cnt_next = fail_cnt_reg;
        unlock_next   = unlock_reg;
        update_next   = 1'b0;
        fail_next     = 1'b0;

        case (state_reg)
            ST_LOCKED: begin
                if (word_accept) begin
                    key_buf_next  = {key_buf_reg[17:0], key_data};
                    word_cnt_next = word_cnt_reg + 2'd1;
                    state_next    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // abort wins over a word offered in the same cycle
                if (abort) begin
                    key_buf_next  = '0;
                    word_cnt_next = '0;
                    state_next    = ST_LOCKED;
                end else if (word_accept) begin
                    key_buf_next  = {key_buf_reg[17:0], key_data};
                    word_cnt_next = word_cnt_reg + 2'd1;
                    if (word_cnt_reg == 2'd3) begin
                        state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                key_buf_next = '0;
                if (key_buf_reg == KEY) begin
                    state_next    = ST_UNLOCKED;
                    unlock_next   = 1'b1;
                    update_next   = 1'b1;
                    tmo_cnt_next  = 8'(TIMEOUT);
                    fail_cnt_next = '0;
                end else begin
                    fail_next  = 1'b1;
                    state_next = ST_LOCKED;
                    if (LOCKOUT_EN) begin
                        fail_cnt_next = fail_cnt_reg + 2'd1;
                        if (fail_cnt_next == 2'(MAX_FAILS)) begin
                            state_next = ST_LOCKOUT;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                // a count of 1 reaches 0 on this edge, so expiry and relock merge into one exit
                if (relock || (tmo_cnt_reg <= 8'd1)) begin
                    state_next   = ST_LOCKED;
                    unlock_next  = 1'b0;
                    update_next  = 1'b1;
                    tmo_cnt_next = '0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg - 8'd1;
                end
            end
            ST_LOCKOUT: begin
                unlock_next = 1'b0;
            end
            default: begin
                state_next  = ST_LOCKED;
                unlock_next = 1'b0;
            end
        endcase
    end

    assign unlock_o     = unlock_reg;
    assign update_o     = update_reg;
    assign fail_o       = fail_reg;
    assign fail_cnt_o   = LOCKOUT_EN ? fail_cnt_reg : 2'b00;
    assign locked_out_o = LOCKOUT_EN && (state_reg == ST_LOCKOUT);

endmodule
